// File: rtl/io_spi_pkg.sv
// Shared types and helpers for the parametrised I/O CPLD SPI master.
package io_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int unsigned clamp_nbits(input int unsigned n, input int unsigned max_bits);
        return (n > max_bits) ? max_bits : n;
    endfunction

endpackage

// File: rtl/io_spi_clkdiv.sv
// Half-period tick generator: fires once every div+1 clk cycles, reloadable on demand.
module io_spi_clkdiv #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = (restart || (cnt_q == '0)) ? div : cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_spi_master.sv
// Multi-device SPI master with CPOL/CPHA modes, programmable word length and SCK divider.
module io_spi_master
    import io_spi_pkg::*;
#(
    parameter int unsigned NUM_DEV  = 3,
    parameter int unsigned MAX_BITS = 16,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                start,
    input  logic [NUM_DEV-1:0]  dev_sel,
    input  logic [LEN_W-1:0]    nbits,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DIV_W-1:0]    div,
    input  logic [MAX_BITS-1:0] tx_data,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                busy,
    output logic                done,
    output logic                irq,
    input  logic                irq_clr,
    output logic [NUM_DEV-1:0]  sck,
    output logic [NUM_DEV-1:0]  csb,
    output logic                sdo,
    input  logic                sdi
);

    spi_state_e            state_q, state_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [LEN_W-1:0]      nbits_q, nbits_d;
    logic [NUM_DEV-1:0]    dev_q, dev_d;
    logic [MAX_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic [MAX_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [MAX_BITS-1:0]   rx_data_q, rx_data_d;
    logic [LEN_W:0]        edge_q, edge_d;
    logic                  lvl_q, lvl_d;
    logic [NUM_DEV-1:0]    sck_q, sck_d;
    logic [NUM_DEV-1:0]    csb_q, csb_d;
    logic                  sdo_q, sdo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  irq_q, irq_d;

    logic                  tick;
    logic                  restart;
    logic [DIV_W-1:0]      div_sel;
    logic [LEN_W-1:0]      nb_clamped;
    logic [LEN_W-1:0]      shamt;
    logic [MAX_BITS-1:0]   tx_al;
    logic [LEN_W:0]        last_edge;
    logic                  leading;

    // Left-align the word so the shifter always emits from the MSB
    assign nb_clamped = LEN_W'(clamp_nbits(32'(nbits), MAX_BITS));
    assign shamt      = LEN_W'(MAX_BITS) - nb_clamped;
    assign tx_al      = tx_data << shamt;
    assign last_edge  = {nbits_q, 1'b0} - 1'b1;
    assign leading    = ~edge_q[0];

    assign restart = (state_d != state_q);
    assign div_sel = (state_q == IDLE) ? div : div_q;

    io_spi_clkdiv #(
        .DIV_W(DIV_W)
    ) u_clkdiv (
        .clk     (clk),
        .rstb    (rstb),
        .restart (restart),
        .div     (div_sel),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        div_d     = div_q;
        nbits_d   = nbits_q;
        dev_d     = dev_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        lvl_d     = lvl_q;
        csb_d     = csb_q;
        sdo_d     = sdo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        irq_d     = irq_q & ~irq_clr;

        case (state_q)
            IDLE: begin
                if (start && (nbits != '0)) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    div_d   = div;
                    nbits_d = nb_clamped;
                    dev_d   = dev_sel;
                    rx_sh_d = '0;
                    edge_d  = '0;
                    lvl_d   = cpol;
                    csb_d   = ~dev_sel;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                    // CPHA=0 must present the first bit before the first SCK edge
                    if (!cpha) begin
                        sdo_d   = tx_al[MAX_BITS-1];
                        tx_sh_d = tx_al << 1;
                    end else begin
                        tx_sh_d = tx_al;
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    lvl_d  = ~lvl_q;
                    edge_d = edge_q + 1'b1;
                    if (leading ^ cpha_q) begin
                        rx_sh_d = {rx_sh_q[MAX_BITS-2:0], sdi};
                    end else begin
                        sdo_d   = tx_sh_q[MAX_BITS-1];
                        tx_sh_d = tx_sh_q << 1;
                    end
                    if (edge_q == last_edge) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                lvl_d = cpol_q;
                if (tick) begin
                    state_d   = IDLE;
                    csb_d     = '1;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    irq_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            sck_d[i] = dev_d[i] ? lvl_d : cpol_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            nbits_q   <= '0;
            dev_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            lvl_q     <= 1'b0;
            sck_q     <= '0;
            csb_q     <= '1;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            div_q     <= div_d;
            nbits_q   <= nbits_d;
            dev_q     <= dev_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            lvl_q     <= lvl_d;
            sck_q     <= sck_d;
            csb_q     <= csb_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            irq_q     <= irq_d;
        end
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign irq     = irq_q;
    assign sck     = sck_q;
    assign csb     = csb_q;
    assign sdo     = sdo_q;

endmodule

// File: tb/tb_io_spi_master.sv
// Directed, table-driven bench for io_spi_master with a loopback path and a mode-3 slave model.
module tb_io_spi_master;
    import io_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start;
    logic [2:0]  dev_sel;
    logic [4:0]  nbits;
    logic        cpol, cpha;
    logic [7:0]  div;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic        busy, done, irq, irq_clr;
    logic [2:0]  sck, csb;
    logic        sdo, sdi;

    logic        loop;
    logic        slv_sdi = 1'b0;
    logic [15:0] slv_word;
    logic [15:0] slv_rx = '0;
    int          slv_cnt = 0;
    logic        sck_prev = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sdi = loop ? sdo : slv_sdi;

    io_spi_master #(
        .NUM_DEV  (3),
        .MAX_BITS (16),
        .DIV_W    (8)
    ) dut (
        .clk     (clk),
        .rstb    (rstb),
        .start   (start),
        .dev_sel (dev_sel),
        .nbits   (nbits),
        .cpol    (cpol),
        .cpha    (cpha),
        .div     (div),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .irq     (irq),
        .irq_clr (irq_clr),
        .sck     (sck),
        .csb     (csb),
        .sdo     (sdo),
        .sdi     (sdi)
    );

    // Mode-3 slave on device 0: drives on falling SCK, samples on rising SCK
    always @(negedge clk) begin
        if (csb[0]) begin
            slv_cnt = 0;
        end else begin
            if (!sck[0] && sck_prev && slv_cnt < 16) begin
                slv_sdi = slv_word[15 - slv_cnt];
                slv_cnt = slv_cnt + 1;
            end
            if (sck[0] && !sck_prev) begin
                slv_rx = {slv_rx[14:0], sdo};
            end
        end
        sck_prev = sck[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_irq();
        @(posedge clk);
        #1 irq_clr = 1'b1;
        @(posedge clk);
        #1 irq_clr = 1'b0;
    endtask

    // Runs one transfer; returns at the negedge where done is seen (lat = cycles from accept)
    task automatic run_xfer(input logic [1:0] mode, input logic [7:0] dv, input logic [4:0] nb,
                            input logic [15:0] tx, input logic [2:0] dev,
                            input int poke_at, input logic [15:0] poke_tx, input int clr_at,
                            output int lat, output int act_bad);
        @(posedge clk);
        #1;
        cpol = mode[1]; cpha = mode[0]; div = dv; nbits = nb;
        tx_data = tx; dev_sel = dev; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        act_bad = 0;
        while (1) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!dev[i] && (csb[i] !== 1'b1 || sck[i] !== mode[1])) act_bad++;
                if (dev[i] && !done && csb[i] !== 1'b0) act_bad++;
            end
            if (!done && busy !== 1'b1) act_bad++;
            if (done === 1'b1) break;
            if (lat >= 3000) begin
                $display("FAIL timeout: done not seen after %0d cycles", lat);
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
            #1;
            start   = (lat == poke_at);
            if (lat == poke_at) tx_data = poke_tx;
            irq_clr = (lat == clr_at);
        end
        #1;
        start   = 1'b0;
        irq_clr = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  dv;
        logic [4:0]  nb;
        logic [15:0] tx;
        logic [2:0]  dev;
        logic        lp;
        logic [15:0] slv_tx;
        logic [15:0] exp_rx;
        logic [15:0] exp_slv;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, act_bad, cnt;

        vecs[0] = '{SPI_MODE0, 8'd0, 5'd8,  16'h00A5, 3'b001, 1'b1, 16'h0000, 16'h00A5, 16'h0000, 18};
        vecs[1] = '{SPI_MODE3, 8'd3, 5'd16, 16'h1234, 3'b001, 1'b0, 16'hBEEF, 16'hBEEF, 16'h1234, 136};
        vecs[2] = '{SPI_MODE1, 8'd1, 5'd20, 16'h0F0F, 3'b010, 1'b1, 16'h0000, 16'h0F0F, 16'h0000, 68};
        vecs[3] = '{SPI_MODE2, 8'd2, 5'd5,  16'hFFF3, 3'b100, 1'b1, 16'h0000, 16'h0013, 16'h0000, 36};
        vecs[4] = '{SPI_MODE0, 8'd0, 5'd4,  16'h00FC, 3'b000, 1'b1, 16'h0000, 16'h000C, 16'h0000, 10};

        rstb = 1'b0; start = 1'b0; dev_sel = '0; nbits = '0; cpol = 1'b0; cpha = 1'b0;
        div = '0; tx_data = '0; irq_clr = 1'b0; loop = 1'b1; slv_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_csb", 32'(csb), 32'h7);
        check("reset_sck", 32'(sck), 32'h0);
        check("reset_sdo_busy_done_irq", {28'h0, sdo, busy, done, irq}, 32'h0);
        check("reset_rx", 32'(rx_data), 32'h0);
        rstb = 1'b1;

        for (int v = 0; v < 5; v++) begin
            clear_irq();
            loop     = vecs[v].lp;
            slv_word = vecs[v].slv_tx;
            run_xfer(vecs[v].mode, vecs[v].dv, vecs[v].nb, vecs[v].tx, vecs[v].dev,
                     -1, 16'h0, -1, lat, act_bad);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_rx", v), 32'(rx_data), 32'(vecs[v].exp_rx));
            check($sformatf("v%0d_busy_at_done", v), 32'(busy), 32'h0);
            check($sformatf("v%0d_irq", v), 32'(irq), 32'h1);
            check($sformatf("v%0d_pins_activity", v), 32'(act_bad), 32'h0);
            if (!vecs[v].lp) check($sformatf("v%0d_slave_rx", v), 32'(slv_rx), 32'(vecs[v].exp_slv));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), 32'(done), 32'h0);
            check($sformatf("v%0d_sck_idle", v), 32'(sck), {29'h0, {3{vecs[v].mode[1]}}});
            check($sformatf("v%0d_csb_idle", v), 32'(csb), 32'h7);
        end

        // start re-pulsed while busy must be ignored
        loop = 1'b1;
        run_xfer(SPI_MODE0, 8'd1, 5'd8, 16'h003C, 3'b001, 5, 16'h00FF, -1, lat, act_bad);
        check("busy_start_latency", 32'(lat), 32'd36);
        check("busy_start_rx", 32'(rx_data), 32'h003C);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("busy_start_no_extra_done", 32'(cnt), 32'h0);

        // reset during SHIFT of a mode-2 transfer (irq and rx_data are non-zero here)
        @(posedge clk);
        #1;
        cpol = 1'b1; cpha = 1'b0; div = 8'd1; nbits = 5'd8; tx_data = 16'h0099;
        dev_sel = 3'b010; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'h1);
        rstb = 1'b0;
        #1;
        check("abort_csb", 32'(csb), 32'h7);
        check("abort_sck", 32'(sck), 32'h0);
        check("abort_busy_done_irq", {29'h0, busy, done, irq}, 32'h0);
        check("abort_rx", 32'(rx_data), 32'h0);
        @(posedge clk);
        #1 rstb = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || irq || busy) cnt++;
        end
        check("abort_no_done_irq", 32'(cnt), 32'h0);
        run_xfer(SPI_MODE0, 8'd0, 5'd8, 16'h00C3, 3'b001, -1, 16'h0, -1, lat, act_bad);
        check("after_abort_latency", 32'(lat), 32'd18);
        check("after_abort_rx", 32'(rx_data), 32'h00C3);
        check("after_abort_pins", 32'(act_bad), 32'h0);

        // nbits=0 start is ignored
        clear_irq();
        @(posedge clk);
        #1 nbits = 5'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy || irq || csb !== 3'b111) cnt++;
        end
        check("nbits0_ignored", 32'(cnt), 32'h0);

        // irq_clr coincident with completion: set wins; a later clear takes effect
        run_xfer(SPI_MODE0, 8'd0, 5'd8, 16'h005A, 3'b001, -1, 16'h0, 17, lat, act_bad);
        check("irqclr_same_cycle_latency", 32'(lat), 32'd18);
        check("irqclr_same_cycle_irq", 32'(irq), 32'h1);
        #1 irq_clr = 1'b1;
        @(posedge clk);
        #1 irq_clr = 1'b0;
        @(negedge clk);
        check("irqclr_next_cycle_irq", 32'(irq), 32'h0);
        check("irqclr_rx_held", 32'(rx_data), 32'h005A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/io_spi_master.md
Name: io_spi_master

Overview:
Parametrised SPI master for the I/O CPLD. It generalises the fixed 8-bit, mode-0, full-speed SPI engine to:
- N one-hot device selects, each with its own gated SCK and chip select
- configurable word length up to MAX_BITS
- CPOL/CPHA modes and a programmable SCK divider
- completion strobe plus sticky interrupt

It sits between the I/O register decode and the flash/LED-driver/peripheral SPI pins.

Parameters:
NUM_DEV, 3, number of SPI devices (SCK/CSb pairs)
MAX_BITS, 16, maximum transfer length in bits; width of tx/rx data
DIV_W, 8, width of divider field; half-period = div+1 clk cycles
LEN_W, $clog2(MAX_BITS+1), width of nbits field

Ports:
clk  in  1  system clock, all state on rising edge
rstb  in  1  asynchronous active-low reset
start  in  1  request transfer; sampled every clk
dev_sel  in  NUM_DEV  one-hot device select, latched at start
nbits  in  LEN_W  transfer length in bits, latched at start
cpol  in  1  SCK idle level, latched at start
cpha  in  1  0: sample leading edge; 1: sample trailing edge; latched at start
div  in  DIV_W  half-period minus one, latched at start
tx_data  in  MAX_BITS  data to send, right-aligned, latched at start
rx_data  out  MAX_BITS  received word, right-aligned, upper bits zero
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at completion
irq  out  1  sticky completion interrupt
irq_clr  in  1  clears irq
sck  out  NUM_DEV  per-device serial clock
csb  out  NUM_DEV  per-device chip select, active low
sdo  out  1  serial data out, MSB first
sdi  in  1  serial data in

Behaviour:
- Reset (rstb low, async) values:
  - csb all 1; sck all 0; latched cpol 0
  - sdo 0, busy 0, done 0, irq 0, rx_data 0
  - FSM to IDLE
- FSM states IDLE, SETUP, SHIFT, HOLD.
- A half-period tick fires every div+1 clk cycles while not IDLE; the counter restarts on every state entry.
- IDLE, start=1, nbits!=0:
  - latch all config; nbits>MAX_BITS clamped to MAX_BITS
  - go to SETUP; busy=1 from the next cycle
- IDLE, start=1, nbits=0: start ignored; no busy, no done.
- start while busy: ignored, no queueing.
- SETUP:
  - csb[i]=0 for each dev_sel bit set; sck at cpol
  - CPHA=0: sdo = first bit on SETUP entry
  - one half-period, then SHIFT
- SHIFT: 2*nbits half-periods; SCK toggles on each tick.
  - CPHA=0: sample sdi on leading edge; drive next bit on trailing edge.
  - CPHA=1: drive bit on leading edge; sample sdi on trailing edge.
  - Shift registers move MSB-first.
- HOLD:
  - sck at cpol; one half-period
  - on exit: csb all 1, rx_data updated, done=1 for one cycle, busy=0 in the same cycle, irq=1; return to IDLE
- Latency: start-accept to done = (div+1)*(2*nbits+2) clk cycles.
- Unselected devices: sck held at latched cpol, csb high.
- dev_sel=0: transfer runs normally with no device enabled; rx_data reflects sdi.
- irq_clr and completion in the same cycle: set wins, irq stays 1.
- rx_data holds its value until the next completion; it is not cleared at start.
- Reset mid-transfer: immediate abort; all outputs return to reset values; no done, no irq.

Decomposition:
- Package io_spi_pkg:
  - state enum (IDLE/SETUP/SHIFT/HOLD)
  - mode constants SPI_MODE0..3 as {cpol,cpha}
  - helper function for clamping nbits
- Sub-module io_spi_clkdiv: DIV_W down-counter producing a half-period tick.
  - Inputs: restart and div.
  - Same clk/rstb as the master.

Test Plan:
- Mode 0, div=0, nbits=8, tx 0xA5, sdo looped to sdi, dev_sel=001 -> rx_data=0x00A5, done exactly 18 cycles after start-accept, only csb[0]/sck[0] active.
- Mode 3, div=3, nbits=16, tx 0x1234, slave model returns 0xBEEF -> slave receives 0x1234, rx_data=0xBEEF, done after 136 cycles, sck idles high.
- start pulsed at cycle 5 of a running transfer with different tx -> ignored; single done; rx unchanged from first transfer.
- nbits=0 -> no busy/done; nbits=20 with MAX_BITS=16 -> 16-bit transfer, latency (div+1)*34.
- irq_clr asserted on the done cycle -> irq=1; irq_clr one cycle later -> irq=0.
- rstb low at mid-SHIFT of mode-2 transfer -> csb=all 1, sck=0, busy=0, no done/irq; a following mode-0 transfer completes correctly.
